// File: rtl/traffic_light_ctrl.sv
// Two-road intersection controller: sequences green/yellow/red phases,
// counts each phase down in whole seconds and supports an all-red
// emergency hold that freezes the countdown.
module traffic_light_ctrl #(
  parameter int unsigned TICK_DIV      = 50000000,
  parameter int unsigned MAIN_GREEN_T  = 30,
  parameter int unsigned MAIN_YELLOW_T = 3,
  parameter int unsigned SIDE_GREEN_T  = 20,
  parameter int unsigned SIDE_YELLOW_T = 3
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       Emergency,
  output logic [2:0] Main_Light,
  output logic [2:0] Side_Light,
  output logic [7:0] Number_Data,
  output logic       Sec_Tick
);

  localparam int unsigned PW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CW  = 8;
  localparam int unsigned SW  = 2;

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  localparam logic [CW-1:0] MG_T = CW'(MAIN_GREEN_T);
  localparam logic [CW-1:0] MY_T = CW'(MAIN_YELLOW_T);
  localparam logic [CW-1:0] SG_T = CW'(SIDE_GREEN_T);
  localparam logic [CW-1:0] SY_T = CW'(SIDE_YELLOW_T);

  localparam logic [SW-1:0] S_MAIN_GREEN  = 2'd0;
  localparam logic [SW-1:0] S_MAIN_YELLOW = 2'd1;
  localparam logic [SW-1:0] S_SIDE_GREEN  = 2'd2;
  localparam logic [SW-1:0] S_SIDE_YELLOW = 2'd3;

  // Light encodings, {R,Y,G}
  localparam logic [2:0] L_RED = 3'b100;
  localparam logic [2:0] L_YEL = 3'b010;
  localparam logic [2:0] L_GRN = 3'b001;

  logic [SW-1:0] r_state;
  logic [CW-1:0] r_rem;
  logic [PW-1:0] r_presc;
  logic          r_emerg;
  logic          r_tick;
  logic [2:0]    r_main;
  logic [2:0]    r_side;
  logic [CW-1:0] r_num;

  logic [SW-1:0] w_state_nxt;
  logic [CW-1:0] w_rem_nxt;
  logic [PW-1:0] w_presc_nxt;
  logic          w_tick_nxt;
  logic [2:0]    w_main_nxt;
  logic [2:0]    w_side_nxt;
  logic [CW-1:0] w_num_nxt;
  logic          w_presc_last;

  assign w_presc_last = (r_presc == PRESC_LAST);

  assign Main_Light  = r_main;
  assign Side_Light  = r_side;
  assign Number_Data = r_num;
  assign Sec_Tick    = r_tick;

  // Next-state, countdown, prescaler and output decode
  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_presc_nxt = r_presc;
    w_tick_nxt  = 1'b0;
    w_main_nxt  = L_RED;
    w_side_nxt  = L_RED;
    w_num_nxt   = '0;

    // The prescaler stays at 0 while emergency is active and on the first
    // edge after release, so the resumed second is shown for a full TICK_DIV.
    if (Emergency || r_emerg) begin
      w_presc_nxt = '0;
    end else if (w_presc_last) begin
      w_presc_nxt = '0;
      w_tick_nxt  = 1'b1;
      if (r_rem > CW'(1)) begin
        w_rem_nxt = r_rem - CW'(1);
      end else begin
        case (r_state)
          S_MAIN_GREEN:  begin w_state_nxt = S_MAIN_YELLOW; w_rem_nxt = MY_T; end
          S_MAIN_YELLOW: begin w_state_nxt = S_SIDE_GREEN;  w_rem_nxt = SG_T; end
          S_SIDE_GREEN:  begin w_state_nxt = S_SIDE_YELLOW; w_rem_nxt = SY_T; end
          default:       begin w_state_nxt = S_MAIN_GREEN;  w_rem_nxt = MG_T; end
        endcase
      end
    end else begin
      w_presc_nxt = r_presc + PW'(1);
    end

    // Lights and display follow the next state so they change on the same edge
    if (!Emergency) begin
      w_num_nxt = w_rem_nxt;
      case (w_state_nxt)
        S_MAIN_GREEN:  begin w_main_nxt = L_GRN; w_side_nxt = L_RED; end
        S_MAIN_YELLOW: begin w_main_nxt = L_YEL; w_side_nxt = L_RED; end
        S_SIDE_GREEN:  begin w_main_nxt = L_RED; w_side_nxt = L_GRN; end
        default:       begin w_main_nxt = L_RED; w_side_nxt = L_YEL; end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state <= S_MAIN_GREEN;
      r_rem   <= MG_T;
      r_presc <= '0;
      r_emerg <= 1'b0;
      r_tick  <= 1'b0;
      r_main  <= L_GRN;
      r_side  <= L_RED;
      r_num   <= MG_T;
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
      r_presc <= w_presc_nxt;
      r_emerg <= Emergency;
      r_tick  <= w_tick_nxt;
      r_main  <= w_main_nxt;
      r_side  <= w_side_nxt;
      r_num   <= w_num_nxt;
    end
  end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed self-checking bench for traffic_light_ctrl.
module tb_traffic_light_ctrl;

  logic       CLK = 1'b0;
  logic       RSTn;
  logic       Emergency;
  logic [2:0] Main_Light;
  logic [2:0] Side_Light;
  logic [7:0] Number_Data;
  logic       Sec_Tick;

  logic       rst6_n;
  logic       emerg6;
  logic [2:0] main6;
  logic [2:0] side6;
  logic [7:0] num6;
  logic       tick6;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  traffic_light_ctrl #(
    .TICK_DIV(4), .MAIN_GREEN_T(5), .MAIN_YELLOW_T(2),
    .SIDE_GREEN_T(4), .SIDE_YELLOW_T(2)
  ) dut (
    .CLK(CLK), .RSTn(RSTn), .Emergency(Emergency),
    .Main_Light(Main_Light), .Side_Light(Side_Light),
    .Number_Data(Number_Data), .Sec_Tick(Sec_Tick)
  );

  traffic_light_ctrl #(
    .TICK_DIV(4), .MAIN_GREEN_T(5), .MAIN_YELLOW_T(1),
    .SIDE_GREEN_T(4), .SIDE_YELLOW_T(2)
  ) dut_min (
    .CLK(CLK), .RSTn(rst6_n), .Emergency(emerg6),
    .Main_Light(main6), .Side_Light(side6),
    .Number_Data(num6), .Sec_Tick(tick6)
  );

  // Compare all four outputs of the main instance against expectations
  task automatic expect_all(input string name, input logic [2:0] em, input logic [2:0] es,
                            input logic [7:0] en, input logic et);
    checks++;
    if (Main_Light !== em) begin
      errors++;
      $display("FAIL %s main_light: got %b expected %b (t=%0t)", name, Main_Light, em, $time);
    end
    checks++;
    if (Side_Light !== es) begin
      errors++;
      $display("FAIL %s side_light: got %b expected %b (t=%0t)", name, Side_Light, es, $time);
    end
    checks++;
    if (Number_Data !== en) begin
      errors++;
      $display("FAIL %s number_data: got %0d expected %0d (t=%0t)", name, Number_Data, en, $time);
    end
    checks++;
    if (Sec_Tick !== et) begin
      errors++;
      $display("FAIL %s sec_tick: got %b expected %b (t=%0t)", name, Sec_Tick, et, $time);
    end
  endtask

  task automatic test_reset();
    RSTn = 1'b0;
    Emergency = 1'b0;
    repeat (3) @(negedge CLK);
    expect_all("reset_held", 3'b001, 3'b100, 8'd5, 1'b0);
    RSTn = 1'b1;
    #1;
    expect_all("reset_released", 3'b001, 3'b100, 8'd5, 1'b0);
  endtask

  // Phase lengths 20/8/16/8 cycles; each value held 4 cycles
  task automatic test_full_cycle();
    logic [2:0] em, es;
    logic [7:0] en;
    logic       et;
    int t;
    for (int k = 1; k <= 52; k++) begin
      @(negedge CLK);
      t = k % 52;
      if (t < 20) begin
        em = 3'b001; es = 3'b100; en = 8'(5 - t / 4);
      end else if (t < 28) begin
        em = 3'b010; es = 3'b100; en = 8'(2 - (t - 20) / 4);
      end else if (t < 44) begin
        em = 3'b100; es = 3'b001; en = 8'(4 - (t - 28) / 4);
      end else begin
        em = 3'b100; es = 3'b010; en = 8'(2 - (t - 44) / 4);
      end
      et = (k % 4 == 0);
      expect_all($sformatf("full_cycle_k%0d", k), em, es, en, et);
    end
  endtask

  task automatic test_emergency_mid();
    // After 52 cycles: MAIN_GREEN, 5. Nine more cycles -> showing 3.
    repeat (9) @(negedge CLK);
    expect_all("emerg_mid_pre", 3'b001, 3'b100, 8'd3, 1'b0);
    Emergency = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      expect_all($sformatf("emerg_mid_hold%0d", i), 3'b100, 3'b100, 8'd0, 1'b0);
    end
    Emergency = 1'b0;
    @(negedge CLK);
    expect_all("emerg_mid_restore", 3'b001, 3'b100, 8'd3, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge CLK);
      expect_all($sformatf("emerg_mid_resume%0d", i), 3'b001, 3'b100, 8'd3, 1'b0);
    end
    @(negedge CLK);
    expect_all("emerg_mid_decrement", 3'b001, 3'b100, 8'd2, 1'b1);
  endtask

  task automatic test_emergency_on_tick();
    // Showing 2 with a fresh second; 15 cycles later MAIN_YELLOW=1 with prescaler at 3
    repeat (15) @(negedge CLK);
    expect_all("emerg_tick_pre", 3'b010, 3'b100, 8'd1, 1'b0);
    Emergency = 1'b1;
    @(negedge CLK);
    expect_all("emerg_tick_suppressed", 3'b100, 3'b100, 8'd0, 1'b0);
    @(negedge CLK);
    expect_all("emerg_tick_hold", 3'b100, 3'b100, 8'd0, 1'b0);
    Emergency = 1'b0;
    @(negedge CLK);
    expect_all("emerg_tick_restore", 3'b010, 3'b100, 8'd1, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge CLK);
      expect_all($sformatf("emerg_tick_resume%0d", i), 3'b010, 3'b100, 8'd1, 1'b0);
    end
    @(negedge CLK);
    expect_all("emerg_tick_side_green", 3'b100, 3'b001, 8'd4, 1'b1);
  endtask

  task automatic test_async_reset();
    repeat (2) @(negedge CLK);
    expect_all("async_pre", 3'b100, 3'b001, 8'd4, 1'b0);
    #2;
    RSTn = 1'b0;
    #1;
    expect_all("async_no_edge", 3'b001, 3'b100, 8'd5, 1'b0);
    @(negedge CLK);
    RSTn = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge CLK);
      expect_all($sformatf("async_after%0d", i), 3'b001, 3'b100, (i == 4) ? 8'd4 : 8'd5, i == 4);
    end
  endtask

  task automatic test_min_duration();
    @(negedge CLK);
    rst6_n = 1'b1;
    repeat (19) @(negedge CLK);
    checks++;
    if (main6 !== 3'b001 || num6 !== 8'd1) begin
      errors++;
      $display("FAIL min_pre: got main=%b num=%0d expected main=001 num=1", main6, num6);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      checks++;
      if (main6 !== 3'b010 || side6 !== 3'b100 || num6 !== 8'd1) begin
        errors++;
        $display("FAIL min_yellow%0d: got main=%b side=%b num=%0d expected main=010 side=100 num=1",
                 i, main6, side6, num6);
      end
    end
    @(negedge CLK);
    checks++;
    if (main6 !== 3'b100 || side6 !== 3'b001 || num6 !== 8'd4 || tick6 !== 1'b1) begin
      errors++;
      $display("FAIL min_side_green: got main=%b side=%b num=%0d tick=%b expected main=100 side=001 num=4 tick=1",
               main6, side6, num6, tick6);
    end
  endtask

  initial begin
    rst6_n = 1'b0;
    emerg6 = 1'b0;
    test_reset();
    test_full_cycle();
    test_emergency_mid();
    test_emergency_on_tick();
    test_async_reset();
    test_min_duration();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
